// File: rtl/debounce_edge.sv
// debounce_edge: glitch filter with registered level, rise/fall strobes and rising-edge counter; DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt.
// Latency: level_out follows DB_CYCLES edges after the first new sample; no backpressure, a sample is taken every cycle.
module debounce_edge #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 16,
  parameter int TMR_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_in,
  input  logic             clr_cnt,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_ovf
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  typedef enum logic [1:0] {S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK} state_t;

  localparam logic [TMR_W-1:0] DB_LAST = TMR_W'(DB_CYCLES - 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             commit_rise, commit_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOW;
      tmr        <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmr        <= tmr_nxt;
      level_out  <= (state_nxt == S_HIGH) || (state_nxt == S_FALL_CHK);
      rise_pulse <= commit_rise;
      fall_pulse <= commit_fall;
    end
  end

  // tmr counts consecutive samples that disagree with the committed level
  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    commit_rise = 1'b0;
    commit_fall = 1'b0;
    case (state)
      S_LOW: begin
        if (sync_in) begin
          state_nxt = S_RISE_CHK;
          tmr_nxt   = TMR_W'(1);
        end else begin
          tmr_nxt   = '0;
        end
      end
      S_RISE_CHK: begin
        if (!sync_in) begin
          state_nxt = S_LOW;
          tmr_nxt   = '0;
        end else if (tmr == DB_LAST) begin
          state_nxt   = S_HIGH;
          tmr_nxt     = '0;
          commit_rise = 1'b1;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync_in) begin
          state_nxt = S_FALL_CHK;
          tmr_nxt   = TMR_W'(1);
        end else begin
          tmr_nxt   = '0;
        end
      end
      S_FALL_CHK: begin
        if (sync_in) begin
          state_nxt = S_HIGH;
          tmr_nxt   = '0;
        end else if (tmr == DB_LAST) begin
          state_nxt   = S_LOW;
          tmr_nxt     = '0;
          commit_fall = 1'b1;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      default: begin
        state_nxt = S_LOW;
        tmr_nxt   = '0;
      end
    endcase
  end

  // clear beats a coinciding rise commit; the strobe path is unaffected
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      edge_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (commit_rise) begin
      edge_cnt <= edge_cnt + CNT_W'(1);
      if (&edge_cnt) cnt_ovf <= 1'b1;
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic glitch_abort;
  assign glitch_abort = ((state == S_RISE_CHK) && !sync_in) ||
                        ((state == S_FALL_CHK) &&  sync_in);

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      glitch_cnt <= '0;
    end else if (glitch_abort) begin
      glitch_cnt <= glitch_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Randomized bench for debounce_edge (DB_CYCLES=4, CNT_W=4) against a run-length reference model.
module tb_debounce_edge;
  localparam int DB    = 4;
  localparam int CNT_W = 4;
  localparam int MODV  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sync_in = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             level_out, rise_pulse, fall_pulse, cnt_ovf;
  logic [CNT_W-1:0] edge_cnt;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [CNT_W-1:0] glitch_cnt;
`endif

  debounce_edge #(.DB_CYCLES(DB), .CNT_W(CNT_W), .TMR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_in    (sync_in),
    .clr_cnt    (clr_cnt),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .edge_cnt   (edge_cnt),
    .cnt_ovf    (cnt_ovf)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference: committed level plus length of the current run of disagreeing samples
  int m_lvl = 0, m_run = 0, m_rise = 0, m_fall = 0, m_cnt = 0, m_ovf = 0, m_glitch = 0;
  int cyc = 0, rise_cyc = 0, fall_cyc = 0, n_rise = 0, n_fall = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model(input int r, input int s, input int c);
    int rise_ev, glitch_ev;
    rise_ev = 0;
    glitch_ev = 0;
    if (r != 0) begin
      m_lvl = 0; m_run = 0; m_rise = 0; m_fall = 0;
      m_cnt = 0; m_ovf = 0; m_glitch = 0;
      return;
    end
    m_rise = 0;
    m_fall = 0;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == DB) begin
        m_lvl = s;
        m_run = 0;
        if (s != 0) begin m_rise = 1; rise_ev = 1; end
        else m_fall = 1;
      end
    end else begin
      if (m_run > 0) glitch_ev = 1;
      m_run = 0;
    end
    if (c != 0) begin
      m_cnt = 0; m_ovf = 0; m_glitch = 0;
    end else begin
      if (rise_ev != 0) begin
        if (m_cnt == MODV - 1) m_ovf = 1;
        m_cnt = (m_cnt + 1) % MODV;
      end
      if (glitch_ev != 0) m_glitch = (m_glitch + 1) % MODV;
    end
  endtask

  // drive one cycle of inputs, advance one edge, compare all outputs to the model
  task automatic step(input logic r, input logic s, input logic c);
    rst = r;
    sync_in = s;
    clr_cnt = c;
    @(posedge clk);
    cyc++;
    model(int'(r), int'(s), int'(c));
    #1;
    check("level_out", int'(level_out), m_lvl);
    check("rise_pulse", int'(rise_pulse), m_rise);
    check("fall_pulse", int'(fall_pulse), m_fall);
    check("edge_cnt", int'(edge_cnt), m_cnt);
    check("cnt_ovf", int'(cnt_ovf), m_ovf);
    check("strobe_excl", int'(rise_pulse & fall_pulse), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_cnt", int'(glitch_cnt), m_glitch);
`endif
    if (rise_pulse) begin n_rise++; rise_cyc = cyc; end
    if (fall_pulse) begin n_fall++; fall_cyc = cyc; end
  endtask

  task automatic run(input logic s, input int n);
    for (int i = 0; i < n; i++) step(1'b0, s, 1'b0);
  endtask

  initial begin
    // reset held with input high
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    check("rst_level", int'(level_out), 0);
    check("rst_cnt", int'(edge_cnt), 0);
    run(1'b1, 3);
    check("pwr_no_early", int'(level_out), 0);
    run(1'b1, 1);
    check("pwr_level", int'(level_out), 1);
    check("pwr_rise", int'(rise_pulse), 1);
    check("pwr_cnt", int'(edge_cnt), 1);

    // return low, then a 3-sample glitch must not commit
    run(1'b0, 6);
    run(1'b1, 3);
    run(1'b0, 4);
    check("glitch_level", int'(level_out), 0);
    check("glitch_cnt_unch", int'(edge_cnt), 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_count", int'(glitch_cnt), 1);
`endif

    // clean toggle: strobes one cycle each, 10 apart
    n_rise = 0; n_fall = 0;
    run(1'b1, 10);
    run(1'b0, 10);
    check("toggle_nrise", n_rise, 1);
    check("toggle_nfall", n_fall, 1);
    check("toggle_gap", fall_cyc - rise_cyc, 10);
    check("toggle_cnt", int'(edge_cnt), 2);

    // wrap: clear first, then 16 clean rising edges
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      run(1'b1, 5);
      run(1'b0, 5);
    end
    check("wrap_cnt", int'(edge_cnt), 0);
    check("wrap_ovf", int'(cnt_ovf), 1);
    step(1'b0, 1'b0, 1'b1);
    check("clr_ovf", int'(cnt_ovf), 0);

    // clear collision at edge_cnt=5
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 5);
      run(1'b0, 5);
    end
    check("pre_coll_cnt", int'(edge_cnt), 5);
    run(1'b1, 3);
    step(1'b0, 1'b1, 1'b1);
    check("coll_cnt", int'(edge_cnt), 0);
    check("coll_rise", int'(rise_pulse), 1);
    run(1'b0, 6);

    // reset mid-debounce
    run(1'b1, 2);
    step(1'b1, 1'b1, 1'b0);
    run(1'b1, 3);
    check("rstmid_no_early", int'(level_out), 0);
    run(1'b1, 1);
    check("rstmid_commit", int'(rise_pulse), 1);
    run(1'b0, 6);

    // randomized runs of varying length against the model
    for (int seg = 0; seg < 400; seg++) begin
      logic s;
      int len;
      s = 1'($urandom_range(1, 0));
      len = int'($urandom_range(7, 1));
      for (int i = 0; i < len; i++) begin
        logic c, r;
        c = ($urandom_range(24, 0) == 0);
        r = ($urandom_range(150, 0) == 0);
        step(r, s, c);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
